// File: rtl/mux_4to1_rr.sv
// Four-channel valid/ready merge with a round-robin arbiter and a registered output stage.
// The output carries the index of the source channel so a downstream demux can route it back.
module mux_4to1_rr #(
   parameter int unsigned width = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [width-1:0] i0,
   input  logic [width-1:0] i1,
   input  logic [width-1:0] i2,
   input  logic [width-1:0] i3,
   input  logic             v0,
   input  logic             v1,
   input  logic             v2,
   input  logic             v3,
   output logic             r0,
   output logic             r1,
   output logic             r2,
   output logic             r3,
   output logic [width-1:0] o,
   output logic [1:0]       sel,
   output logic             o_valid,
   input  logic             o_ready
);

   logic [width-1:0] o_q, o_d;
   logic [1:0]       sel_q, sel_d;
   logic             o_valid_q, o_valid_d;
   logic [1:0]       last_q, last_d;

   logic             ld;
   logic [3:0]       v;
   logic [3:0]       grant;
   logic [3:0]       r;
   logic [1:0]       gidx;
   logic [1:0]       idx;
   logic             gany;
   logic [width-1:0] gdata;

   assign v  = {v3, v2, v1, v0};
   assign ld = !o_valid_q | o_ready;

   // Scan last+1, last+2, last+3, last (mod 4); the first requester wins.
   always_comb begin
      gany = 1'b0;
      gidx = last_q;
      idx  = last_q;
      for (int k = 1; k <= 4; k++) begin
         idx = last_q + 2'(k);
         if (!gany && v[idx]) begin
            gany = 1'b1;
            gidx = idx;
         end
      end
      grant       = 4'b0000;
      grant[gidx] = gany;
   end

   always_comb begin
      case (gidx)
         2'd0:    gdata = i0;
         2'd1:    gdata = i1;
         2'd2:    gdata = i2;
         default: gdata = i3;
      endcase
   end

   // Reset gating keeps every ready low while the block is held in reset.
   assign r  = {4{ld & rst_n}} & grant;
   assign r0 = r[0];
   assign r1 = r[1];
   assign r2 = r[2];
   assign r3 = r[3];

   always_comb begin
      o_d       = o_q;
      sel_d     = sel_q;
      o_valid_d = o_valid_q;
      last_d    = last_q;
      if (ld) begin
         if (gany) begin
            o_d       = gdata;
            sel_d     = gidx;
            o_valid_d = 1'b1;
            last_d    = gidx;
         end else begin
            o_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_q       <= '0;
         sel_q     <= 2'b00;
         o_valid_q <= 1'b0;
         last_q    <= 2'b11;
      end else begin
         o_q       <= o_d;
         sel_q     <= sel_d;
         o_valid_q <= o_valid_d;
         last_q    <= last_d;
      end
   end

   assign o       = o_q;
   assign sel     = sel_q;
   assign o_valid = o_valid_q;

endmodule
